// File: rtl/alarm_key_pkg.sv
// Key codes, FSM state encoding and key classification helpers shared by the
// alarm-clock keypad path.
package alarm_key_pkg;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  typedef enum logic [2:0] {
    StShowTime       = 3'd0,
    StKeyStored      = 3'd1,
    StKeyWaited      = 3'd2,
    StKeyEntry       = 3'd3,
    StShowAlarm      = 3'd4,
    StSetAlarmTime   = 3'd5,
    StSetCurrentTime = 3'd6
  } key_state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  // Codes 0xC-0xE are unused on the keypad and behave exactly like no key.
  function automatic logic is_none(input logic [3:0] key);
    return key >= 4'hC;
  endfunction

endpackage

// File: rtl/key_entry_fsm_if.sv
// Keypad-side signal bundle: key code and 1 Hz tick in, shift/display/load controls out.
interface key_entry_fsm_if;

  logic       one_second;
  logic [3:0] key;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_alarm;
  logic       load_new_time;

  modport master (
    output one_second,
    output key,
    input  shift,
    input  show_new_time,
    input  show_a,
    input  load_new_alarm,
    input  load_new_time
  );

  modport slave (
    input  one_second,
    input  key,
    output shift,
    output show_new_time,
    output show_a,
    output load_new_alarm,
    output load_new_time
  );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a stability filter: a key code is passed on only
// once two consecutive synchronised samples agree.
module key_debounce
  import alarm_key_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_i,
  output logic [3:0] key_o
);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] key_d, key_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= KEY_NONE;
      sync2_q <= KEY_NONE;
      key_q   <= KEY_NONE;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      key_q   <= key_d;
    end
  end

  always_comb begin
    key_d = key_q;
    if (sync1_q == sync2_q) begin
      key_d = sync2_q;
    end
  end

  assign key_o = key_q;

endmodule

// File: rtl/key_entry_fsm.sv
// Keypad entry controller: one shift pulse per key press, idle-session timeout,
// load strobes and display selects. Define KEY_DEBOUNCE_EN to filter the key input.
module key_entry_fsm
  import alarm_key_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef KEY_DEBOUNCE_EN
  output logic [3:0]            key_out,
`endif
  key_entry_fsm_if.slave        kbd
);

  localparam int unsigned CntW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_SEC - 1);

  logic [3:0] key;

`ifdef KEY_DEBOUNCE_EN
  key_debounce u_key_debounce (
    .clock (clock),
    .reset (reset),
    .key_i (kbd.key),
    .key_o (key)
  );
  assign key_out = key;
`else
  assign key = kbd.key;
`endif

  key_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            armed_d, armed_q;
  logic            timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StShowTime;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // A key still held when SHOW_TIME is (re)entered must be released before it counts.
  assign armed_d = is_none(key);

  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == StKeyEntry || state_q == StKeyWaited) begin
      timeout = (cnt_q == CntLast) && kbd.one_second;
      cnt_d   = kbd.one_second ? cnt_q + 1'b1 : cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StShowTime: begin
        if (armed_q) begin
          if (is_digit(key)) begin
            state_d = StKeyStored;
          end else if (key == KEY_ALARM) begin
            state_d = StShowAlarm;
          end
        end
      end
      StKeyStored: state_d = StKeyWaited;
      StKeyWaited: begin
        if (is_none(key)) begin
          state_d = StKeyEntry;
        end else if (timeout) begin
          state_d = StShowTime;
        end
      end
      StKeyEntry: begin
        if (is_digit(key)) begin
          state_d = StKeyStored;
        end else if (key == KEY_ALARM) begin
          state_d = StSetAlarmTime;
        end else if (key == KEY_TIME) begin
          state_d = StSetCurrentTime;
        end else if (timeout) begin
          state_d = StShowTime;
        end
      end
      StShowAlarm: begin
        if (is_none(key)) begin
          state_d = StShowTime;
        end
      end
      StSetAlarmTime:   state_d = StShowTime;
      StSetCurrentTime: state_d = StShowTime;
      default:          state_d = StShowTime;
    endcase
  end

  assign kbd.shift          = (state_q == StKeyStored);
  assign kbd.show_new_time  = (state_q == StKeyEntry) || (state_q == StKeyStored) ||
                              (state_q == StKeyWaited);
  assign kbd.show_a         = (state_q == StShowAlarm);
  assign kbd.load_new_alarm = (state_q == StSetAlarmTime);
  assign kbd.load_new_time  = (state_q == StSetCurrentTime);

endmodule

// File: tb/tb_key_entry_fsm.sv
// Scoreboard bench for key_entry_fsm: directed sessions plus random keypad traffic,
// checked every cycle against a session-level reference model.
module tb_key_entry_fsm;

  localparam int unsigned TIMEOUT_SEC = 10;
  localparam int          WRAP        = 1 << $clog2(TIMEOUT_SEC);
  localparam logic [3:0]  KN          = 4'hF;
  localparam logic [3:0]  KA          = 4'hA;
  localparam logic [3:0]  KB          = 4'hB;

  logic clock = 1'b0;
  logic reset;

  key_entry_fsm_if kbd ();

  key_entry_fsm #(.TIMEOUT_SEC(TIMEOUT_SEC)) dut (
    .clock (clock),
    .reset (reset),
    .kbd   (kbd)
  );

  always #5 clock = ~clock;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Shift register fed by the DUT, as in the real clock.
  logic [15:0] tb_digits = '0;
  always @(posedge clock) if (kbd.shift === 1'b1) tb_digits <= {tb_digits[11:0], kbd.key};

  // Reference model: session mode plus the one-cycle event happening this cycle.
  typedef enum int {MIdle, MAlarm, MEntry} mode_e;
  typedef enum int {PNone, PShift, PLoadAlarm, PLoadTime} pulse_e;

  mode_e       m_mode   = MIdle;
  pulse_e      m_pulse  = PNone;
  bit          m_held   = 1'b0;
  bit          m_armed  = 1'b0;
  int          m_ticks  = 0;
  logic [15:0] m_digits = '0;

  typedef struct {
    int          cyc;
    logic [4:0]  outs;
    logic [15:0] digits;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [3:0] k, input logic t, input logic r);
    bit none_k;
    bit active;
    bit timeout;
    none_k = (k >= 4'hC);
    // The shift register captures on the edge that ends the shift cycle, reset or not.
    if (m_pulse == PShift) m_digits = {m_digits[11:0], k};
    if (r) begin
      m_mode  = MIdle;
      m_pulse = PNone;
      m_held  = 1'b0;
      m_ticks = 0;
      m_armed = 1'b0;
      return;
    end
    active  = (m_mode == MEntry) && (m_pulse != PShift);
    timeout = active && t && (m_ticks == TIMEOUT_SEC - 1);
    m_ticks = active ? (t ? (m_ticks + 1) % WRAP : m_ticks) : 0;
    if (m_pulse == PLoadAlarm || m_pulse == PLoadTime) begin
      m_pulse = PNone;
      m_mode  = MIdle;
    end else if (m_pulse == PShift) begin
      m_pulse = PNone;
      m_held  = 1'b1;
    end else begin
      case (m_mode)
        MIdle: begin
          if (m_armed) begin
            if (k <= 4'd9) begin
              m_mode  = MEntry;
              m_pulse = PShift;
            end else if (k == KA) begin
              m_mode = MAlarm;
            end
          end
        end
        MAlarm: if (none_k) m_mode = MIdle;
        default: begin
          if (m_held) begin
            if (none_k) m_held = 1'b0;
            else if (timeout) m_mode = MIdle;
          end else if (k <= 4'd9) begin
            m_pulse = PShift;
          end else if (k == KA) begin
            m_mode  = MIdle;
            m_pulse = PLoadAlarm;
          end else if (k == KB) begin
            m_mode  = MIdle;
            m_pulse = PLoadTime;
          end else if (timeout) begin
            m_mode = MIdle;
          end
        end
      endcase
    end
    m_armed = none_k;
  endtask

  task automatic drive(input logic [3:0] k, input logic t, input logic r);
    exp_t e;
    reset          = r;
    kbd.key        = k;
    kbd.one_second = t;
    model_step(k, t, r);
    e.cyc    = cyc + 1;
    e.outs   = {m_pulse == PShift, m_mode == MEntry, m_mode == MAlarm,
                m_pulse == PLoadAlarm, m_pulse == PLoadTime};
    e.digits = m_digits;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) drive(k, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) drive(KN, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT against every expectation due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_expectation: cycle %0d expected at %0d", cyc, e.cyc);
        end else begin
          check("shift",          16'(kbd.shift),          16'(e.outs[4]));
          check("show_new_time",  16'(kbd.show_new_time),  16'(e.outs[3]));
          check("show_a",         16'(kbd.show_a),         16'(e.outs[2]));
          check("load_new_alarm", 16'(kbd.load_new_alarm), 16'(e.outs[1]));
          check("load_new_time",  16'(kbd.load_new_time),  16'(e.outs[0]));
          check("digits",         tb_digits,               e.digits);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a digit held: nothing may happen until a release.
    repeat (3) drive(4'h3, 1'b0, 1'b1);
    repeat (3) drive(4'h3, 1'b0, 1'b0);
    repeat (5) drive(KN, 1'b0, 1'b0);

    // Entry 1,2,3,4 committed to current time.
    for (int d = 1; d <= 4; d++) press(4'(d), 5, 1);
    press(KB, 2, 2);
    check("buffer_after_time_entry", tb_digits, 16'h1234);

    // Entry 5,6,7,8 committed to alarm.
    for (int d = 5; d <= 8; d++) press(4'(d), 5, 1);
    press(KA, 1, 2);
    check("buffer_after_alarm_entry", tb_digits, 16'h5678);

    // Alarm display while held.
    press(KA, 20, 3);

    // Idle timeout after a single digit.
    press(4'h7, 3, 1);
    for (int i = 0; i < 10; i++) begin
      drive(KN, 1'b1, 1'b0);
      drive(KN, 1'b0, 1'b0);
      drive(KN, 1'b0, 1'b0);
    end
    press(KN, 3, 0);

    // Digit arriving with the final timeout tick keeps the session alive.
    press(4'h7, 3, 1);
    for (int i = 0; i < 9; i++) begin
      drive(KN, 1'b1, 1'b0);
      drive(KN, 1'b0, 1'b0);
    end
    drive(4'h5, 1'b1, 1'b0);
    press(4'h5, 3, 1);
    press(KB, 1, 2);
    check("buffer_digit_beats_timeout", {8'h00, tb_digits[7:0]}, 16'h0075);

    // Reset while waiting for a held key to release.
    press(4'h2, 3, 0);
    drive(4'h2, 1'b0, 1'b1);
    press(4'h2, 3, 3);

    // Random keypad traffic.
    for (int n = 0; n < 400; n++) begin
      int         r;
      int         hold;
      int         gap;
      logic [3:0] k;
      r = int'($urandom_range(0, 99));
      if (r < 50)      k = 4'($urandom_range(0, 9));
      else if (r < 65) k = KA;
      else if (r < 80) k = KB;
      else if (r < 90) k = 4'($urandom_range(12, 14));
      else             k = KN;
      hold = int'($urandom_range(1, 6));
      gap  = int'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++)
        drive(k, $urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0);
      for (int i = 0; i < gap; i++)
        drive(KN, $urandom_range(0, 2) == 0, 1'b0);
      if ($urandom_range(0, 29) == 0) repeat (40) drive(KN, 1'b1, 1'b0);
    end

    drive(KN, 1'b0, 1'b0);
    drive(KN, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
